// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - R-type func field to ALU operation, with legality flag
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] alu_op,
    output logic       func_valid
);

    always_comb begin
        alu_op     = ALU_ADD;
        func_valid = 1'b1;
        case (func)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: func_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS control FSM sequencing a shared datapath
module multi_cycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALU_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal
);

    state_t     cur_state, nxt_state;
    logic [2:0] dec_alu_op;
    logic       func_valid;
    // The branch decision is made in the datapath via PCWriteCond & zero.
    logic       unused_zero;

    assign unused_zero = zero;
    assign state       = cur_state;

    mc_alu_decode u_alu_decode (
        .func       (func),
        .alu_op     (dec_alu_op),
        .func_valid (func_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) cur_state <= S_FETCH;
        else     cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state   = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        ALU_op      = ALU_ADD;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        case (cur_state)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                PCWrite   = mem_ready;
                IRWrite   = mem_ready;
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE: begin
                        nxt_state = func_valid ? S_EXEC : S_FETCH;
                        illegal   = !func_valid;
                    end
                    OP_BEQ:  nxt_state = S_BRANCH;
                    OP_J:    nxt_state = S_JUMP;
                    OP_ADDI: nxt_state = S_ADDI_EX;
                    default: illegal   = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                nxt_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                nxt_state  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA   = 1'b1;
                ALU_op    = dec_alu_op;
                nxt_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALU_op      = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                nxt_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase

        // Reset overrides the decode so an in-flight access is dropped this cycle.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_FOUR;
            PCSource    = PCSRC_ALU;
            ALU_op      = ALU_ADD;
            instr_done  = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed scoreboard bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, func;
    logic       zero, mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALU_op;
    logic [3:0] state;
    logic       instr_done, illegal;

    int total = 0;
    int bad   = 0;

    // {state[4], PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
    //  RegDst, RegWrite, ALUSrcA, ALUSrcB[2], PCSource[2], ALU_op[3], instr_done, illegal}
    typedef struct {
        logic [22:0] vec;
        string       tag;
    } exp_t;
    exp_t sb[$];

    multi_cycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALU_op(ALU_op), .state(state), .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [22:0] pack(input logic [3:0] st, input logic pcw, pcwc, iord,
                                         mrd, mwr, irw, m2r, rdst, rw, srca,
                                         input logic [1:0] srcb, pcs,
                                         input logic [2:0] alu, input logic done, ill);
        return {st, pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcs, alu, done, ill};
    endfunction

    // Reference table of the control word each state must present.
    function automatic logic [22:0] spec_word(input logic [3:0] st, input logic mr,
                                              input logic [2:0] alu, input logic ill);
        case (st)
            4'd0:  return pack(st, mr, 0, 0, 1, 0, mr, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
            4'd1:  return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, ill);
            4'd2:  return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0);
            4'd3:  return pack(st, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0);
            4'd4:  return pack(st, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 1, 0);
            4'd5:  return pack(st, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, mr, 0);
            4'd6:  return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu, 0, 0);
            4'd7:  return pack(st, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b010, 1, 0);
            4'd8:  return pack(st, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1, 0);
            4'd9:  return pack(st, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 1, 0);
            4'd10: return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0);
            4'd11: return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010, 1, 0);
            default: return '0;
        endcase
    endfunction

    function automatic logic [22:0] rst_word(input logic [3:0] st);
        return pack(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
    endfunction

    task automatic check_cycle();
        exp_t e;
        logic [22:0] obs;
        @(negedge clk);
        obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALU_op, instr_done, illegal};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty obs=%h exp=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.vec) else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.vec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic mr,
                        input logic [2:0] alu = 3'b010, input logic ill = 1'b0);
        exp_t e;
        mem_ready = mr;
        e.vec = spec_word(st, mr, alu, ill);
        e.tag = tag;
        sb.push_back(e);
        check_cycle();
    endtask

    task automatic step_rst(input string tag, input logic [3:0] st, input logic mr);
        exp_t e;
        rst = 1'b1;
        mem_ready = mr;
        e.vec = rst_word(st);
        e.tag = tag;
        sb.push_back(e);
        check_cycle();
    endtask

    initial begin
        rst = 1'b1; op = 6'b100011; func = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        step_rst("reset_a", 4'd0, 1'b1);
        step_rst("reset_b", 4'd0, 1'b0);
        rst = 1'b0;

        // lw, mem_ready high throughout
        op = 6'b100011;
        step("lw_fetch", 4'd0, 1);
        step("lw_decode", 4'd1, 1);
        step("lw_memadr", 4'd2, 1);
        step("lw_memrd", 4'd3, 1);
        step("lw_memwb", 4'd4, 1);

        // sw with fetch wait, ignored mem_ready in decode, three MEMWR wait cycles
        op = 6'b101011;
        step("sw_fetch_wait", 4'd0, 0);
        step("sw_fetch", 4'd0, 1);
        step("sw_decode_mr0", 4'd1, 0);
        step("sw_memadr", 4'd2, 1);
        step("sw_memwr_w1", 4'd5, 0);
        step("sw_memwr_w2", 4'd5, 0);
        step("sw_memwr_w3", 4'd5, 0);
        step("sw_memwr_done", 4'd5, 1);

        // R-type slt
        op = 6'b000000; func = 6'b101010;
        step("slt_fetch", 4'd0, 1);
        step("slt_decode", 4'd1, 1);
        step("slt_exec", 4'd6, 1, 3'b111);
        step("slt_aluwb", 4'd7, 1);

        // R-type sub and and
        func = 6'b100010;
        step("sub_fetch", 4'd0, 1);
        step("sub_decode", 4'd1, 1);
        step("sub_exec", 4'd6, 1, 3'b110);
        step("sub_aluwb", 4'd7, 1);
        func = 6'b100100;
        step("and_fetch", 4'd0, 1);
        step("and_decode", 4'd1, 1);
        step("and_exec", 4'd6, 0, 3'b000);
        step("and_aluwb", 4'd7, 1);

        // addi
        op = 6'b001000;
        step("addi_fetch", 4'd0, 1);
        step("addi_decode", 4'd1, 1);
        step("addi_ex", 4'd10, 1);
        step("addi_wb", 4'd11, 1);

        // beq, zero low then high
        op = 6'b000100; zero = 1'b0;
        step("beq0_fetch", 4'd0, 1);
        step("beq0_decode", 4'd1, 1);
        step("beq0_branch", 4'd8, 1);
        zero = 1'b1;
        step("beq1_fetch", 4'd0, 1);
        step("beq1_decode", 4'd1, 1);
        step("beq1_branch", 4'd8, 0);
        zero = 1'b0;

        // j
        op = 6'b000010;
        step("j_fetch", 4'd0, 1);
        step("j_decode", 4'd1, 1);
        step("j_jump", 4'd9, 1);

        // illegal opcode, then illegal R-type func
        op = 6'b111111;
        step("illop_fetch", 4'd0, 1);
        step("illop_decode", 4'd1, 1, 3'b010, 1'b1);
        op = 6'b000000; func = 6'b000000;
        step("illfn_fetch", 4'd0, 1);
        step("illfn_decode", 4'd1, 1, 3'b010, 1'b1);

        // reset while waiting in MEMRD
        op = 6'b100011; func = 6'b100000;
        step("rlw_fetch", 4'd0, 1);
        step("rlw_decode", 4'd1, 1);
        step("rlw_memadr", 4'd2, 1);
        step("rlw_memrd_wait", 4'd3, 0);
        step_rst("rlw_rst_in_memrd", 4'd3, 0);
        step_rst("rlw_rst_held", 4'd0, 1);
        rst = 1'b0;
        step("rlw_fetch_hold1", 4'd0, 0);
        step("rlw_fetch_hold2", 4'd0, 0);
        step("rlw_fetch_go", 4'd0, 1);
        step("rlw_decode2", 4'd1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Multi-cycle MIPS control FSM that sequences the shared datapath: one ALU, one unified instruction/data memory, IR, PC and register file. It replaces per-instruction combinational decode with a state machine that issues per-state enables and mux selects. It holds memory accesses until the memory handshakes with `mem_ready`. It sits between the datapath and the memory interface.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `op` in 6: IR[31:26], valid from DECODE onward.
- `func` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1: datapath controls.
- `ALUSrcB` out 2: selects 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `PCSource` out 2: selects 00 ALU result, 01 ALUOut register, 10 jump target.
- `ALU_op` out 3: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- `state` out 4: current state, for debug.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: one-cycle pulse when an unsupported op or func is decoded.

## Operation
- States and their outputs. Any output not listed is 0. ALU_op defaults to add.
  - FETCH=0: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSource=00. PCWrite and IRWrite equal `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11 (branch target goes into ALUOut). Next state by op:
    - lw 100011 or sw 101011 → MEMADR
    - R-type 000000 → EXEC
    - beq 000100 → BRANCH
    - j 000010 → JUMP
    - addi 001000 → ADDI_EX
    - anything else → FETCH, with `illegal`=1.
    - R-type func must be one of 100000, 100010, 100100, 100101, 101010; any other func is illegal.
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD=3: MemRead=1, IorD=1. Hold until `mem_ready`, then go to MEMWB.
  - MEMWB=4: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Go to FETCH.
  - MEMWR=5: MemWrite=1, IorD=1. Hold until `mem_ready`; instr_done equals `mem_ready`. Then go to FETCH.
  - EXEC=6: ALUSrcA=1, ALUSrcB=00. ALU_op from func: add→010, sub→110, and→000, or→001, slt→111. Go to ALUWB.
  - ALUWB=7: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Go to FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALU_op=110, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
  - JUMP=9: PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
  - ADDI_EX=10: ALUSrcA=1, ALUSrcB=10. Go to ADDI_WB.
  - ADDI_WB=11: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Go to FETCH.
  - Encodings 12–15 are unreachable. If entered, go to FETCH with all enables 0.
- Outputs are Moore, decoded from `state`. The only Mealy terms are PCWrite/IRWrite in FETCH and instr_done in MEMWR, all gated by `mem_ready`.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.

## Timing
- Reset:
  - While `rst`=1, every enable (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, instr_done, illegal) is forced to 0.
  - Selects take their FETCH values.
  - `state` becomes 0 at the first clock edge with `rst` high.
  - The first cycle after `rst` falls is FETCH.
- Reset mid-access abandons the access. MemRead/MemWrite drop combinationally in the same cycle.
- Cycles per instruction with `mem_ready` tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each wait cycle at a memory state adds 1.
- A `mem_ready` pulse that arrives together with the state's first cycle completes the access in 1 cycle.
- beq with `zero`=0: PC is unchanged; the FETCH PC+4 write stands.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum (4-bit, values as above)
  - op constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - func constants
  - ALU_op encodings
  - ALUSrcB/PCSource select encodings
- Sub-module `mc_alu_decode`: combinational func → ALU_op, plus a `func_valid` output. Used in EXEC and for the DECODE legality check.
- Top level: state register, next-state logic, output decode.

## Test plan
- lw, `mem_ready`=1 throughout → state sequence 0,1,2,3,4. IRWrite/PCWrite high in cycle 0; RegWrite=1 with MemtoReg=1 in cycle 4; instr_done only in cycle 4.
- sw, `mem_ready` low for 3 cycles in MEMWR → MemWrite=1 for 4 cycles. instr_done in the 4th cycle, then FETCH.
- R-type func=101010 → EXEC shows ALU_op=111; ALUWB shows RegDst=1, RegWrite=1. Total 4 cycles.
- beq → BRANCH has PCWriteCond=1, PCSource=01, ALU_op=110, for both `zero`=0 and `zero`=1. j → JUMP has PCWrite=1, PCSource=10.
- op=111111, and separately R-type func=000000 → `illegal` pulses in DECODE, next state FETCH, RegWrite/MemWrite never asserted.
- `rst` asserted in MEMRD while waiting → MemRead=0 that cycle, state=0 next edge. After release, FETCH holds until `mem_ready`.
